// File: rtl/uart_tx_buffer_if.sv
// Byte-write and transmitter-handshake bundle for the UART transmit buffer.
// Latency: none, wires only.
// Backpressure: writer watches full/overflow; the transmitter paces frames via tx_done.
interface uart_tx_buffer_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          clr_ovf;
  logic          tx_done;
  logic [7:0]    tx_data;
  logic          tx_enable;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;

  // Writer/transmitter side (bench or host logic).
  modport master (
    output wr_en, wr_data, clr_ovf, tx_done,
    input  tx_data, tx_enable, full, empty, count, overflow
  );

  // Buffer side.
  modport slave (
    input  wr_en, wr_data, clr_ovf, tx_done,
    output tx_data, tx_enable, full, empty, count, overflow
  );
endinterface

// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding a UART transmitter one frame at a time, with an idle gap between frames.
// Latency: byte written into an empty idle buffer at cycle N raises tx_enable at N+3.
// Backpressure: writes while full are dropped and flagged in sticky overflow; frames wait for tx_done rising.
module uart_tx_buffer #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Final gap_cnt value before returning to IDLE; a zero gap still spends one cycle in GAP.
  localparam logic [7:0] GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  state_t        state;
  logic [7:0]    tx_data_q;
  logic          tx_enable_q;
  logic [7:0]    gap_cnt;
  logic          done_q;

  logic full_w;
  logic empty_w;
  logic push;
  logic pop;
  logic drop;
  logic done_rise;

  assign full_w    = (count_q == CW'(DEPTH));
  assign empty_w   = (count_q == '0);
  // A write against a full buffer is dropped even if a pop frees a slot this cycle.
  assign push      = bus.wr_en && !full_w;
  assign drop      = bus.wr_en && full_w;
  assign pop       = (state == IDLE) && !empty_w;
  assign done_rise = bus.tx_done && !done_q;

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_enable = tx_enable_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;

  // Byte storage; contents are don't-care after reset so no reset branch.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
      // A drop wins over a clear in the same cycle so no lost write goes unreported.
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Frame sequencer: pop, one cycle of data setup, request until tx_done rises, then idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_data_q   <= 8'h00;
      tx_enable_q <= 1'b0;
      gap_cnt     <= 8'd0;
      done_q      <= 1'b0;
    end else begin
      done_q <= bus.tx_done;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data_q <= mem[rd_ptr];
            state     <= LOAD;
          end
        end
        LOAD: begin
          tx_enable_q <= 1'b1;
          state       <= SEND;
        end
        SEND: begin
          // Only a rising edge seen while sending ends the frame.
          if (done_rise) begin
            tx_enable_q <= 1'b0;
            gap_cnt     <= 8'd0;
            state       <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: directed scenarios plus a frame-order scoreboard.
// Latency: checks the write-to-request timing and gap length cycle by cycle.
// Backpressure: transmitter is modelled by pulsing tx_done; buffer fill drives overflow.
module tb_uart_tx_buffer;
  localparam int DEPTH = 8;
  localparam int GAP   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  uart_tx_buffer_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_buffer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic       prev_en = 1'b0;

  // Scoreboard: every rising tx_enable must present the oldest accepted byte.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = 1'b0;
    end else begin
      if (bus.tx_enable && !prev_en) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL frame_unexpected: got tx_data=%h, required no frame", bus.tx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (bus.tx_data !== mon_exp) begin
            n_fail++;
            $display("FAIL frame_order: got tx_data=%h, required %h", bus.tx_data, mon_exp);
          end
        end
      end
      prev_en = bus.tx_enable;
    end
  end

  task automatic do_reset;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_ovf = 1'b0;
    bus.tx_done = 1'b0;
    rst_n       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] d, input bit accept);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    if (accept) exp_q.push_back(d);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_enable(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.tx_enable === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_enable: tx_enable=0 after 100 cycles, required 1");
    end
  endtask

  // Hold the current frame for 'hold' cycles, pulse tx_done, let the gap elapse.
  task automatic drain_one(input int hold);
    bit ok;
    wait_enable(ok);
    if (ok) begin
      repeat (hold) @(negedge clk);
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
      n_tests++;
      if (bus.tx_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL drop_enable: tx_enable=%b, required 0", bus.tx_enable);
      end
      repeat (GAP + 1) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_ovf = 1'b0;
    bus.tx_done = 1'b0;
    rst_n       = 1'b0;
    #2;
    n_tests++; if (bus.tx_enable !== 1'b0) begin n_fail++; $display("FAIL rst_tx_enable: got %b, required 0", bus.tx_enable); end
    n_tests++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h, required 00", bus.tx_data); end
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d, required 0", bus.count); end
    n_tests++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_fail++; $display("FAIL rst_flags: empty=%b full=%b, required 1 0", bus.empty, bus.full); end
    n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b, required 0", bus.overflow); end
  endtask

  task automatic test_single;
    do_reset();
    repeat (5) @(negedge clk);
    write_byte(8'hA5, 1'b1);
    n_tests++; if (bus.count !== 4'd1 || bus.tx_enable !== 1'b0) begin n_fail++; $display("FAIL single_n1: count=%0d en=%b, required 1 0", bus.count, bus.tx_enable); end
    @(negedge clk);
    n_tests++; if (bus.tx_enable !== 1'b0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL single_n2: en=%b empty=%b, required 0 1", bus.tx_enable, bus.empty); end
    @(negedge clk);
    n_tests++; if (bus.tx_enable !== 1'b1 || bus.tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_n3: en=%b data=%h, required 1 a5", bus.tx_enable, bus.tx_data); end
    repeat (27) @(negedge clk);
    n_tests++; if (bus.tx_enable !== 1'b1) begin n_fail++; $display("FAIL single_hold: en=%b, required 1", bus.tx_enable); end
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    n_tests++; if (bus.tx_enable !== 1'b0) begin n_fail++; $display("FAIL single_done: en=%b, required 0", bus.tx_enable); end
    // A byte written at the start of the gap must wait out all GAP cycles.
    write_byte(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    n_tests++; if (bus.tx_enable !== 1'b0) begin n_fail++; $display("FAIL gap_early: en=%b, required 0", bus.tx_enable); end
    @(negedge clk);
    n_tests++; if (bus.tx_enable !== 1'b1 || bus.tx_data !== 8'h5A) begin n_fail++; $display("FAIL gap_len: en=%b data=%h, required 1 5a", bus.tx_enable, bus.tx_data); end
    drain_one(2);
  endtask

  task automatic test_overflow;
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      write_byte(8'(i), i <= 9);
      if (i == 8) begin
        n_tests++; if (bus.count !== 4'd7 || bus.full !== 1'b0) begin n_fail++; $display("FAIL ovf_cnt7: count=%0d full=%b, required 7 0", bus.count, bus.full); end
      end
      if (i == 9) begin
        n_tests++; if (bus.count !== 4'd8 || bus.full !== 1'b1 || bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_full: count=%0d full=%b ovf=%b, required 8 1 0", bus.count, bus.full, bus.overflow); end
      end
      if (i == 10) begin
        n_tests++; if (bus.count !== 4'd8 || bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: count=%0d ovf=%b, required 8 1", bus.count, bus.overflow); end
      end
    end
    bus.clr_ovf = 1'b1;
    write_byte(8'hEE, 1'b0);
    bus.clr_ovf = 1'b0;
    n_tests++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_clr_vs_drop: ovf=%b, required 1", bus.overflow); end
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: ovf=%b, required 0", bus.overflow); end
    for (int i = 0; i < 9; i++) drain_one(3);
    n_tests++; if (exp_q.size() != 0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drain: pending=%0d empty=%b, required 0 1", exp_q.size(), bus.empty); end
  endtask

  task automatic test_order_wrap;
    do_reset();
    for (int i = 0; i < 8; i++) write_byte(8'(8'h10 + i), 1'b1);
    for (int i = 8; i < 20; i++) begin
      drain_one(20);
      write_byte(8'(8'h10 + i), 1'b1);
    end
    for (int i = 0; i < 8; i++) drain_one(20);
    n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf: ovf=%b, required 0", bus.overflow); end
    n_tests++; if (exp_q.size() != 0 || bus.count !== 4'd0) begin n_fail++; $display("FAIL wrap_drain: pending=%0d count=%0d, required 0 0", exp_q.size(), bus.count); end
  endtask

  task automatic test_simultaneous;
    bit ok;
    do_reset();
    write_byte(8'h30, 1'b1);
    write_byte(8'h31, 1'b1);
    write_byte(8'h32, 1'b1);
    write_byte(8'h33, 1'b1);
    wait_enable(ok);
    n_tests++; if (bus.count !== 4'd3) begin n_fail++; $display("FAIL simul_pre: count=%0d, required 3", bus.count); end
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++; if (bus.count !== 4'd3 || bus.tx_enable !== 1'b0) begin n_fail++; $display("FAIL simul_idle: count=%0d en=%b, required 3 0", bus.count, bus.tx_enable); end
    write_byte(8'h34, 1'b1);
    n_tests++; if (bus.count !== 4'd3) begin n_fail++; $display("FAIL simul_count: count=%0d, required 3", bus.count); end
    for (int i = 0; i < 4; i++) drain_one(3);
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL simul_drain: pending=%0d, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit seen;
    do_reset();
    for (int i = 0; i < 6; i++) write_byte(8'(8'h40 + i), 1'b1);
    wait_enable(ok);
    n_tests++; if (bus.count !== 4'd5) begin n_fail++; $display("FAIL mid_pre: count=%0d, required 5", bus.count); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.tx_enable !== 1'b0 || bus.count !== 4'd0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL mid_async: en=%b count=%0d empty=%b, required 0 0 1", bus.tx_enable, bus.count, bus.empty); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.tx_enable !== 1'b0) seen = 1'b1;
    end
    n_tests++; if (seen) begin n_fail++; $display("FAIL mid_quiet: tx_enable seen=1, required 0"); end
    write_byte(8'h4F, 1'b1);
    drain_one(3);
  endtask

  task automatic test_done_held;
    do_reset();
    bus.tx_done = 1'b1;
    write_byte(8'h77, 1'b1);
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (bus.tx_enable !== 1'b1) begin n_fail++; $display("FAIL held_start: en=%b, required 1", bus.tx_enable); end
    repeat (10) @(negedge clk);
    n_tests++; if (bus.tx_enable !== 1'b1) begin n_fail++; $display("FAIL held_level: en=%b, required 1", bus.tx_enable); end
    bus.tx_done = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.tx_enable !== 1'b1) begin n_fail++; $display("FAIL held_fall: en=%b, required 1", bus.tx_enable); end
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    n_tests++; if (bus.tx_enable !== 1'b0) begin n_fail++; $display("FAIL held_rise: en=%b, required 0", bus.tx_enable); end
    repeat (GAP + 2) @(negedge clk);
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL held_drain: pending=%0d, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_order_wrap();
    test_simultaneous();
    test_reset_mid();
    test_done_held();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_buffer.md
UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in bytes; SHALL be a power of two, 2 to 64.
REQ-002 Parameter GAP_CYCLES, default 4, idle clk cycles inserted between consecutive frames; SHALL be 0 to 255.
REQ-003 clk  input  1  system clock; all state SHALL change on its rising edge except reset.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  write strobe; one byte is offered per cycle while high.
REQ-006 wr_data  input  8  byte to enqueue, sampled with wr_en.
REQ-007 clr_ovf  input  1  synchronous clear of overflow.
REQ-008 tx_done  input  1  transmitter done flag, synchronous to clk; only its 0->1 transition is meaningful.
REQ-009 tx_data  output  8  byte presented to the transmitter, registered.
REQ-010 tx_enable  output  1  transmit request to the transmitter, registered.
REQ-011 full  output  1  high when count == DEPTH.
REQ-012 empty  output  1  high when count == 0.
REQ-013 count  output  clog2(DEPTH)+1  number of stored bytes, excluding the byte in transmission.
REQ-014 overflow  output  1  sticky flag, set when a write is dropped.

Function
REQ-015 The storage SHALL be a circular buffer with read and write pointers of clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-016 A write SHALL be accepted when wr_en=1 and full=0: wr_data is stored at the write pointer, the pointer advances, and count increments.
REQ-017 When wr_en=1 and full=1, the write SHALL be dropped and overflow set the next cycle, even if a pop occurs in the same cycle.
REQ-018 When a pop and an accepted write occur in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-019 When clr_ovf=1, overflow SHALL clear the next cycle; if clr_ovf=1 and a dropped write occur together, overflow SHALL remain 1.
REQ-020 The FSM SHALL have the states IDLE, LOAD, SEND and GAP.
REQ-021 IDLE: if empty=0, the FSM SHALL pop the head byte into tx_data and go to LOAD; otherwise it stays in IDLE.
REQ-022 LOAD: the FSM SHALL go to SEND unconditionally. This gives tx_data one cycle of setup before the request.
REQ-023 SEND: tx_enable SHALL be 1. tx_enable and tx_data SHALL be held until a 0->1 edge of tx_done is detected.
REQ-024 tx_done edge detection SHALL use a registered copy of tx_done. An edge detected in SEND SHALL set tx_enable=0 the next cycle and move the FSM to GAP.
REQ-025 An edge of tx_done outside SEND SHALL be ignored.
REQ-026 GAP: the FSM SHALL stay for GAP_CYCLES cycles using an 8-bit counter, then go to IDLE.
REQ-027 With GAP_CYCLES=0, GAP SHALL last exactly one cycle.
REQ-028 Latency: a byte written into an empty, idle buffer at cycle N SHALL produce tx_enable=1 at cycle N+3 (write at N, pop at N+1, LOAD at N+2, SEND at N+3).
REQ-029 Bytes SHALL be transmitted in write order; none SHALL be duplicated or lost except dropped writes.
REQ-030 tx_enable SHALL be 0 in IDLE, LOAD and GAP.
REQ-031 tx_data SHALL change only on a pop.

Reset
REQ-032 While rst_n=0, the following SHALL be forced asynchronously, with no clock needed:
- tx_enable=0, tx_data=8'h00, overflow=0
- count=0, empty=1, full=0
- both pointers 0, FSM in IDLE, gap counter 0, tx_done edge register 0
REQ-033 A reset during SEND SHALL abandon the byte in flight. Buffered bytes SHALL be discarded.
REQ-034 Memory contents need not be cleared.
REQ-035 After rst_n rises, the first clk edge SHALL behave as in IDLE with empty=1.

Verification
REQ-036 Single byte: write 8'hA5 at cycle 10 -> tx_enable=1 and tx_data=8'hA5 at cycle 13. Pulse tx_done at cycle 40 -> tx_enable=0 at 41 and GAP for 4 cycles, then IDLE.
REQ-037 Fill and overflow, DEPTH=8, transmitter stalled (tx_done held 0):
- write 10 bytes 8'h01..8'h0A
- first byte is popped into SEND; count reaches 7, then 8 with full=1
- 8'h0A is dropped -> overflow=1
- clr_ovf -> overflow=0
REQ-038 Ordering and wrap: stream 20 bytes 8'h10..8'h23 with tx_done pulsed every 30 cycles -> tx_data sequence equals 8'h10..8'h23, pointers wrap twice, overflow stays 0.
REQ-039 Simultaneous write and pop: count=3, FSM in IDLE, wr_en=1 on the pop cycle -> count stays 3 and the new byte emerges last.
REQ-040 Reset mid-frame: assert rst_n=0 while in SEND with count=5 -> tx_enable=0, count=0, empty=1 immediately without a clock edge. After release, no tx_enable until a new write.
REQ-041 tx_done held high through IDLE and LOAD, then staying high in SEND -> no edge is detected and tx_enable stays 1 until tx_done goes 0 then 1.
